// File: rtl/sequenciador_rpn.sv
`default_nettype none
// ============================================================================
// Module   : sequenciador_rpn
// Purpose  : Execution sequencer for the RPN stack. On an execute request it
//            pops one or two operands, starts the ULA, waits for its answer
//            (bounded by TIMEOUT cycles) and pushes the result back as the
//            new top. It reports completion and a two-bit status code.
// Ports    : clk, rst              - clock, asynchronous active-high reset
//            i_exec_req/i_operacao - execute request and operation code
//            i_profundidade/i_topo - stack depth and current top
//            o_pop/o_push/o_push_dado - stack strobes and push data
//            o_operando_a/b, o_operacao_ula, o_ula_start - ULA request
//            i_ula_pronto/i_ula_resultado/i_ula_erro      - ULA answer
//            o_ocupado/o_concluido/o_erro_codigo          - status
// Revision : 1.0 - initial release
// ============================================================================
module sequenciador_rpn #(
  parameter int         WIDTH     = 8,
  parameter logic [2:0] OP_UNARIO = 3'b111,
  parameter int         TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_exec_req,
  input  logic [2:0]       i_operacao,
  input  logic [2:0]       i_profundidade,
  input  logic [WIDTH-1:0] i_topo,
  output logic             o_pop,
  output logic             o_push,
  output logic [WIDTH-1:0] o_push_dado,
  output logic [WIDTH-1:0] o_operando_a,
  output logic [WIDTH-1:0] o_operando_b,
  output logic [2:0]       o_operacao_ula,
  output logic             o_ula_start,
  input  logic             i_ula_pronto,
  input  logic [WIDTH-1:0] i_ula_resultado,
  input  logic             i_ula_erro,
  output logic             o_ocupado,
  output logic             o_concluido,
  output logic [1:0]       o_erro_codigo
);

  // Counter must be able to hold the value TIMEOUT itself.
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] c_ERR_OK        = 2'b00;
  localparam logic [1:0] c_ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] c_ERR_ULA       = 2'b10;
  localparam logic [1:0] c_ERR_TIMEOUT   = 2'b11;

  typedef enum logic [2:0] {
    S_OCIOSO  = 3'd0,
    S_POP_A   = 3'd1,
    S_POP_B   = 3'd2,
    S_INICIA  = 3'd3,
    S_ESPERA  = 3'd4,
    S_EMPILHA = 3'd5,
    S_FIM     = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cont;
  logic [WIDTH-1:0] r_push_dado;
  logic [WIDTH-1:0] r_operando_a;
  logic [WIDTH-1:0] r_operando_b;
  logic [2:0]       r_operacao;
  logic [1:0]       r_erro;

  logic             w_req_unario;
  logic [2:0]       w_prof_min;
  logic             w_underflow;
  logic             w_op_unario;
  logic             w_timeout;

  // Depth check uses the live code; later states use the latched one.
  assign w_req_unario = (i_operacao == OP_UNARIO);
  assign w_prof_min   = w_req_unario ? 3'd1 : 3'd2;
  assign w_underflow  = (i_profundidade < w_prof_min);
  assign w_op_unario  = (r_operacao == OP_UNARIO);
  // r_cont counts completed ESPERA cycles; equality means TIMEOUT have passed.
  assign w_timeout    = (r_cont == CW'(TIMEOUT));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_OCIOSO;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    w_next      = r_state;
    o_pop       = 1'b0;
    o_push      = 1'b0;
    o_ula_start = 1'b0;
    o_concluido = 1'b0;
    o_ocupado   = (r_state != S_OCIOSO);
    case (r_state)
      S_OCIOSO: begin
        if (i_exec_req) begin
          w_next = w_underflow ? S_FIM : S_POP_A;
        end
      end
      S_POP_A: begin
        o_pop  = 1'b1;
        w_next = w_op_unario ? S_INICIA : S_POP_B;
      end
      S_POP_B: begin
        o_pop  = 1'b1;
        w_next = S_INICIA;
      end
      S_INICIA: begin
        o_ula_start = 1'b1;
        w_next      = S_ESPERA;
      end
      S_ESPERA: begin
        if (i_ula_pronto) begin
          w_next = i_ula_erro ? S_FIM : S_EMPILHA;
        end else if (w_timeout) begin
          w_next = S_FIM;
        end
      end
      S_EMPILHA: begin
        o_push = 1'b1;
        w_next = S_FIM;
      end
      S_FIM: begin
        o_concluido = 1'b1;
        w_next      = S_OCIOSO;
      end
      default: begin
        w_next = S_OCIOSO;
      end
    endcase
  end

  // Operand, result, status and wait-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cont       <= '0;
      r_push_dado  <= '0;
      r_operando_a <= '0;
      r_operando_b <= '0;
      r_operacao   <= '0;
      r_erro       <= c_ERR_OK;
    end else begin
      case (r_state)
        S_OCIOSO: begin
          if (i_exec_req) begin
            r_operacao <= i_operacao;
            r_erro     <= w_underflow ? c_ERR_UNDERFLOW : c_ERR_OK;
          end
        end
        S_POP_A: begin
          r_operando_a <= i_topo;
          if (w_op_unario) begin
            r_operando_b <= '0;
          end
        end
        S_POP_B: begin
          // Stack top already reflects the first pop here.
          r_operando_b <= i_topo;
        end
        S_INICIA: begin
          r_cont <= '0;
        end
        S_ESPERA: begin
          if (i_ula_pronto) begin
            if (i_ula_erro) begin
              r_erro <= c_ERR_ULA;
            end else begin
              r_push_dado <= i_ula_resultado;
            end
          end else if (w_timeout) begin
            r_erro <= c_ERR_TIMEOUT;
          end else begin
            r_cont <= r_cont + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_push_dado    = r_push_dado;
  assign o_operando_a   = r_operando_a;
  assign o_operando_b   = r_operando_b;
  assign o_operacao_ula = r_operacao;
  assign o_erro_codigo  = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_sequenciador_rpn.sv
`default_nettype none
// ============================================================================
// Module   : tb_sequenciador_rpn
// Purpose  : Self-checking bench for sequenciador_rpn. Hosts a queue-based
//            stack and a ULA responder, and predicts each request's outcome
//            (operands, result, latency, status, final stack) from the
//            initial stack contents with plain arithmetic.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sequenciador_rpn;

  localparam int TIMEOUT = 16;

  logic       clk;
  logic       rst;
  logic       i_exec_req;
  logic [2:0] i_operacao;
  logic [2:0] i_profundidade;
  logic [7:0] i_topo;
  logic       o_pop;
  logic       o_push;
  logic [7:0] o_push_dado;
  logic [7:0] o_operando_a;
  logic [7:0] o_operando_b;
  logic [2:0] o_operacao_ula;
  logic       o_ula_start;
  logic       i_ula_pronto;
  logic [7:0] i_ula_resultado;
  logic       i_ula_erro;
  logic       o_ocupado;
  logic       o_concluido;
  logic [1:0] o_erro_codigo;

  sequenciador_rpn #(.WIDTH(8), .OP_UNARIO(3'b111), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_exec_req     (i_exec_req),
    .i_operacao     (i_operacao),
    .i_profundidade (i_profundidade),
    .i_topo         (i_topo),
    .o_pop          (o_pop),
    .o_push         (o_push),
    .o_push_dado    (o_push_dado),
    .o_operando_a   (o_operando_a),
    .o_operando_b   (o_operando_b),
    .o_operacao_ula (o_operacao_ula),
    .o_ula_start    (o_ula_start),
    .i_ula_pronto   (i_ula_pronto),
    .i_ula_resultado(i_ula_resultado),
    .i_ula_erro     (i_ula_erro),
    .o_ocupado      (o_ocupado),
    .o_concluido    (o_concluido),
    .o_erro_codigo  (o_erro_codigo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stack contents, top at the back of the queue.
  logic [7:0] stk[$];

  // ULA responder controls
  int ula_delay  = 0;
  bit ula_err    = 0;
  bit ula_never  = 0;
  bit ula_glitch = 0;

  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a & ~b;
      3'd6:    return b - a;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [63:0] pack_q(input logic [7:0] q[$]);
    logic [63:0] v;
    v = 64'(q.size());
    foreach (q[i]) v = (v << 8) | 64'(q[i]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    i_profundidade = 3'(stk.size());
    i_topo         = (stk.size() > 0) ? stk[stk.size()-1] : 8'h00;
  endtask

  task automatic load_stack(input int n);
    stk.delete();
    for (int i = 0; i < n; i++) stk.push_back(8'($urandom));
    refresh();
  endtask

  // ULA model: answers the start pulse after 1+ula_delay cycles.
  initial begin
    logic [7:0] a, b;
    logic [2:0] op;
    i_ula_pronto = 1'b0; i_ula_erro = 1'b0; i_ula_resultado = 8'h00;
    forever begin
      @(negedge clk);
      if (o_ula_start) begin
        a = o_operando_a; b = o_operando_b; op = o_operacao_ula;
        if (ula_glitch) begin
          // Answer during the start cycle; must be ignored by the sequencer.
          i_ula_pronto = 1'b1; i_ula_erro = 1'b1; i_ula_resultado = 8'hEE;
        end
        if (!ula_never) begin
          for (int k = 0; k < ula_delay; k++) begin
            @(negedge clk);
            i_ula_pronto = 1'b0; i_ula_erro = 1'b0;
          end
          @(negedge clk);
          i_ula_pronto = 1'b1; i_ula_erro = ula_err; i_ula_resultado = ref_alu(op, a, b);
        end
        @(negedge clk);
        i_ula_pronto = 1'b0; i_ula_erro = 1'b0;
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input int delay, input bit err, input bit never,
                        input bit glitch, input bit busy, input bit rst_mid);
    logic [7:0] exp_q[$];
    logic [7:0] ea, eb, eres, pd, pend_dado;
    logic [1:0] e_err, got_err;
    int depth, req, e_lat, e_pops, e_push, base;
    int pops, pushes, push_cyc, conc_cyc, extra_conc;
    bit unary, done, pend_pop, pend_push;
    depth = stk.size();
    unary = (op == 3'b111);
    req   = unary ? 1 : 2;
    exp_q = stk;
    ea = 8'h00; eb = 8'h00; eres = 8'h00;
    if (depth < req) begin
      e_err = 2'b01; e_lat = 1; e_pops = 0; e_push = 0;
    end else begin
      ea = stk[depth-1];
      eb = unary ? 8'h00 : stk[depth-2];
      repeat (req) void'(exp_q.pop_back());
      e_pops = req;
      base   = unary ? 3 : 4;
      if (never) begin
        e_err = 2'b11; e_lat = base + TIMEOUT + 1; e_push = 0;
      end else if (err) begin
        e_err = 2'b10; e_lat = base + delay + 1; e_push = 0;
      end else begin
        e_err = 2'b00; e_lat = base + delay + 2; e_push = 1;
        eres  = ref_alu(op, ea, eb);
        exp_q.push_back(eres);
      end
    end
    ula_delay = delay; ula_err = err; ula_never = never; ula_glitch = glitch;

    @(negedge clk);
    i_exec_req = 1'b1; i_operacao = op;
    @(posedge clk); #1;
    i_exec_req = 1'b0;

    pops = 0; pushes = 0; push_cyc = 0; conc_cyc = 0; done = 0;
    pd = 8'h00; got_err = 2'b00;
    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      @(negedge clk);
      pend_pop = o_pop; pend_push = o_push; pend_dado = o_push_dado;
      if (o_pop) pops++;
      if (o_push) begin pushes++; pd = o_push_dado; push_cyc = cyc; end
      if (o_concluido) begin done = 1; conc_cyc = cyc; got_err = o_erro_codigo; end
      if (rst_mid && cyc == 6) begin
        rst = 1'b1; #1;
        check("rst_mid_outputs_zero",
              {o_pop, o_push, o_push_dado, o_operando_a, o_operando_b, o_operacao_ula,
               o_ula_start, o_concluido, o_ocupado, o_erro_codigo}, 64'd0);
        check("rst_mid_pops", 64'(pops), 64'(e_pops));
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (busy && cyc == 2) i_exec_req = 1'b1;
      if (busy && cyc == 3) i_exec_req = 1'b0;
      if (!done) begin
        @(posedge clk); #1;
        if (pend_pop && stk.size() > 0) void'(stk.pop_back());
        if (pend_push) stk.push_back(pend_dado);
        refresh();
      end
    end
    if (!done) check("concluido_never_seen", 64'd0, 64'd1);
    check("concluido_cycle", 64'(conc_cyc), 64'(e_lat));
    check("erro_codigo", 64'(got_err), 64'(e_err));
    check("pop_count", 64'(pops), 64'(e_pops));
    check("push_count", 64'(pushes), 64'(e_push));
    if (e_push == 1) begin
      check("push_dado", 64'(pd), 64'(eres));
      check("push_cycle", 64'(push_cyc), 64'(e_lat - 1));
    end
    if (depth >= req) begin
      check("operando_a", 64'(o_operando_a), 64'(ea));
      check("operando_b", 64'(o_operando_b), 64'(eb));
      check("operacao_ula", 64'(o_operacao_ula), 64'(op));
    end
    check("stack_after", pack_q(stk), pack_q(exp_q));
    @(negedge clk);
    check("ocupado_after", 64'(o_ocupado), 64'd0);
    if (busy) begin
      extra_conc = 0;
      repeat (5) begin
        @(negedge clk);
        if (o_concluido) extra_conc++;
      end
      check("busy_extra_concluido", 64'(extra_conc), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; i_exec_req = 1'b0; i_operacao = 3'd0;
    stk.delete(); refresh();
    repeat (3) @(negedge clk);
    check("reset_outputs_zero",
          {o_pop, o_push, o_push_dado, o_operando_a, o_operando_b, o_operacao_ula,
           o_ula_start, o_concluido, o_ocupado, o_erro_codigo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Binary add 5+3, ULA answers immediately, spurious pronto during start.
    stk.delete(); stk.push_back(8'h03); stk.push_back(8'h05); refresh();
    run_op(3'b000, 0, 0, 0, 1, 0, 0);

    // Underflow: depth 1 binary, depth 0 unary.
    load_stack(1);
    run_op(3'b000, 0, 0, 0, 0, 0, 0);
    load_stack(0);
    run_op(3'b111, 0, 0, 0, 0, 0, 0);

    // Unary NOT of 0x0F.
    stk.delete(); stk.push_back(8'h0F); refresh();
    run_op(3'b111, 0, 0, 0, 0, 0, 0);

    // ULA error with a wait cycle, then timeout.
    load_stack(3);
    run_op(3'b001, 1, 1, 0, 0, 0, 0);
    load_stack(2);
    run_op(3'b010, 0, 0, 1, 0, 0, 0);

    // Reset during ESPERA, then a normal request.
    load_stack(4);
    run_op(3'b011, 0, 0, 1, 0, 0, 1);
    load_stack(2);
    run_op(3'b100, 2, 0, 0, 0, 0, 0);

    // exec_req pulsed while busy.
    load_stack(3);
    run_op(3'b110, 1, 0, 0, 0, 1, 0);

    // Randomized requests.
    for (int t = 0; t < 30; t++) begin
      int r;
      load_stack($urandom_range(0, 4));
      r = $urandom_range(0, 9);
      run_op(3'($urandom_range(0, 7)), $urandom_range(0, 3), r < 2, r == 9,
             1'($urandom_range(0, 1)), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
